// File: rtl/perceptron_pkg.sv
// perceptron_pkg: constants and types shared by the perceptron datapath
// (mac_sequencer, mac, downstream activation logic).
//   DATA_W  : width of the x and w operands
//   ACC_W   : accumulator width (MAC out / previous_out)
//   MAC_LAT : MAC register depth (multiply, accumulate, output)
//   seq_state_t : sequencer state, exported for observation
package perceptron_pkg;

   localparam int DATA_W  = 4;
   localparam int ACC_W   = 8;
   localparam int MAC_LAT = 3;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } seq_state_t;

endpackage

// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: groups the operand-load port, the run control/status
// signals and the MAC-facing operand/feedback bus of mac_sequencer.
//   slave  : the sequencer side (mac_sequencer itself)
//   master : the side that loads operands, starts runs and models the MAC
// Load handshake: a pair (load_x, load_w) transfers on a rising edge where
// load_valid and load_ready are both 1. load_ready never depends on
// load_valid; load_valid while load_ready is 0 is simply dropped.
// state_dbg mirrors the sequencer FSM state for observation.
interface mac_sequencer_if #(
   parameter int DATA_W = perceptron_pkg::DATA_W,
   parameter int ACC_W  = perceptron_pkg::ACC_W
);
   import perceptron_pkg::*;

   logic              clear;
   logic              load_valid;
   logic [DATA_W-1:0] load_x;
   logic [DATA_W-1:0] load_w;
   logic              load_ready;
   logic              start;
   logic              busy;
   logic [DATA_W-1:0] mac_x;
   logic [DATA_W-1:0] mac_w;
   logic [ACC_W-1:0]  mac_prev;
   logic [ACC_W-1:0]  mac_out;
   logic [ACC_W-1:0]  result;
   logic              result_valid;
   logic              overflow;
   seq_state_t        state_dbg;

   modport slave (
      input  clear, load_valid, load_x, load_w, start, mac_out,
      output load_ready, busy, mac_x, mac_w, mac_prev, result,
             result_valid, overflow, state_dbg
   );

   modport master (
      output clear, load_valid, load_x, load_w, start, mac_out,
      input  load_ready, busy, mac_x, mac_w, mac_prev, result,
             result_valid, overflow, state_dbg
   );

endinterface

// File: rtl/operand_regfile.sv
// operand_regfile: N_INPUTS-entry store of (x, w) operand pairs.
//   clk    : clock
//   wr_en  : write the pair at wr_idx on the rising edge
//   wr_idx : write slot
//   wr_x/wr_w : pair to write
//   rd_idx : combinational read slot
//   rd_x/rd_w : pair at rd_idx
// Contents are deliberately not reset; the sequencer's fill count decides
// which slots hold valid data.
module operand_regfile #(
   parameter int N_INPUTS = 4,
   parameter int DATA_W   = 4,
   parameter int IDX_W    = 2
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_x,
   input  logic [DATA_W-1:0] wr_w,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_x,
   output logic [DATA_W-1:0] rd_w
);
   import perceptron_pkg::*;

   logic [DATA_W-1:0] x_mem [N_INPUTS];
   logic [DATA_W-1:0] w_mem [N_INPUTS];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         x_mem[wr_idx] <= wr_x;
         w_mem[wr_idx] <= wr_w;
      end
   end

   assign rd_x = x_mem[rd_idx];
   assign rd_w = w_mem[rd_idx];

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: buffers N_INPUTS (x, w) pairs, then on start feeds them one
// term at a time to the pipelined MAC, holding each operand set for MAC_LAT+1
// cycles and feeding each MAC result back as previous_out. Presents the final
// ACC_W-bit dot product with a one-cycle result_valid pulse and a sticky
// overflow (unsigned wrap) flag.
//   clk   : clock
//   rst_n : synchronous active-low reset (shared with the MAC)
//   bus   : mac_sequencer_if.slave (load port, start/clear, status, MAC bus)
module mac_sequencer #(
   parameter int N_INPUTS = 4,
   parameter int DATA_W   = perceptron_pkg::DATA_W,
   parameter int ACC_W    = perceptron_pkg::ACC_W,
   parameter int MAC_LAT  = perceptron_pkg::MAC_LAT
) (
   input logic            clk,
   input logic            rst_n,
   mac_sequencer_if.slave bus
);
   import perceptron_pkg::*;

   localparam int CNT_W  = $clog2(N_INPUTS + 1);
   localparam int IDX_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam int WCNT_W = $clog2(MAC_LAT + 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(N_INPUTS);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_INPUTS - 1);
   localparam logic [WCNT_W-1:0] WCNT_CAP = WCNT_W'(MAC_LAT);

   logic [0:0]        state;
   logic [CNT_W-1:0]  count;
   logic [IDX_W-1:0]  idx;
   logic [WCNT_W-1:0] wcnt;
   logic [DATA_W-1:0] mac_x_q, mac_w_q;
   logic [ACC_W-1:0]  mac_prev_q, result_q;
   logic              result_valid_q, overflow_q;

   logic              load_ready, load_fire, start_ok, capture;
   logic [IDX_W-1:0]  rd_idx;
   logic [DATA_W-1:0] rd_x, rd_w;

   assign load_ready = (state == ST_IDLE) && (count < CNT_FULL);
   assign load_fire  = bus.load_valid && load_ready && !bus.clear;
   assign start_ok   = (state == ST_IDLE) && (count == CNT_FULL) && bus.start;
   assign capture    = (state == ST_RUN) && (wcnt == WCNT_CAP);

   // In IDLE the read port looks at slot 0 (first term of the next run);
   // in RUN it looks one slot ahead so the next term is ready at capture.
   assign rd_idx = (state == ST_RUN) ? idx + IDX_W'(1) : '0;

   operand_regfile #(
      .N_INPUTS (N_INPUTS),
      .DATA_W   (DATA_W),
      .IDX_W    (IDX_W)
   ) u_regfile (
      .clk    (clk),
      .wr_en  (rst_n && load_fire),
      .wr_idx (count[IDX_W-1:0]),
      .wr_x   (bus.load_x),
      .wr_w   (bus.load_w),
      .rd_idx (rd_idx),
      .rd_x   (rd_x),
      .rd_w   (rd_w)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         count          <= '0;
         idx            <= '0;
         wcnt           <= '0;
         mac_x_q        <= '0;
         mac_w_q        <= '0;
         mac_prev_q     <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         overflow_q     <= 1'b0;
      end else if (bus.clear) begin
         // Abort: result and overflow keep the last completed run's values.
         state          <= ST_IDLE;
         count          <= '0;
         idx            <= '0;
         wcnt           <= '0;
         result_valid_q <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         if (capture) begin
            // Unsigned products: a running sum that shrinks has wrapped.
            if (bus.mac_out < mac_prev_q) overflow_q <= 1'b1;
            wcnt <= '0;
            if (idx < IDX_LAST) begin
               idx        <= idx + IDX_W'(1);
               mac_x_q    <= rd_x;
               mac_w_q    <= rd_w;
               mac_prev_q <= bus.mac_out;
            end else begin
               result_q       <= bus.mac_out;
               result_valid_q <= 1'b1;
               count          <= '0;
               state          <= ST_IDLE;
            end
         end else if (state == ST_RUN) begin
            wcnt <= wcnt + WCNT_W'(1);
         end else if (start_ok) begin
            state      <= ST_RUN;
            idx        <= '0;
            wcnt       <= '0;
            mac_x_q    <= rd_x;
            mac_w_q    <= rd_w;
            mac_prev_q <= '0;
            overflow_q <= 1'b0;
         end else if (load_fire) begin
            count <= count + CNT_W'(1);
         end
      end
   end

   assign bus.load_ready   = load_ready;
   assign bus.busy         = (state == ST_RUN);
   assign bus.mac_x        = mac_x_q;
   assign bus.mac_w        = mac_w_q;
   assign bus.mac_prev     = mac_prev_q;
   assign bus.result       = result_q;
   assign bus.result_valid = result_valid_q;
   assign bus.overflow     = overflow_q;
   assign bus.state_dbg    = seq_state_t'(state);

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: drives mac_sequencer with directed and random operand
// sets, models the 3-stage MAC it feeds, and compares each completion
// against a dot-product reference computed with plain integer arithmetic.
module tb_mac_sequencer;
   import perceptron_pkg::*;

   localparam int N   = 4;
   localparam int DW  = DATA_W;
   localparam int AW  = ACC_W;
   localparam int LAT = MAC_LAT;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mac_sequencer_if bus ();

   mac_sequencer #(.N_INPUTS(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- MAC model (multiply, accumulate, output) ----------------
   logic [AW-1:0] m_prod, m_prev_d, m_acc, m_out;
   always @(posedge clk) begin
      if (!rst_n) begin
         m_prod   <= '0;
         m_prev_d <= '0;
         m_acc    <= '0;
         m_out    <= '0;
      end else begin
         m_prod   <= AW'(bus.mac_x) * AW'(bus.mac_w);
         m_prev_d <= bus.mac_prev;
         m_acc    <= m_prod + m_prev_d;
         m_out    <= m_acc;
      end
   end
   assign bus.mac_out = m_out;

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;
   int n_runs   = 0;
   int n_pulses = 0;
   logic [AW-1:0] last_res = '0;
   logic          last_ov  = 1'b0;
   logic [AW:0]   exp_q[$];
   logic [AW:0]   mon_e;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Scoreboard: every result_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (bus.result_valid === 1'b1) begin
         n_pulses++;
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("result", bus.result, mon_e[AW-1:0]);
            check("overflow", bus.overflow, mon_e[AW]);
         end
      end
   end

   // Reference: modulo-2^AW running sum; a term wraps if the true sum reaches 2^AW.
   function automatic logic [AW:0] ref_dot(input int xs[N], input int ws[N]);
      int  sum = 0;
      bit  ov  = 0;
      for (int i = 0; i < N; i++) begin
         sum = sum + xs[i] * ws[i];
         if (sum >= (1 << AW)) begin
            ov  = 1;
            sum = sum % (1 << AW);
         end
      end
      return {ov, AW'(sum)};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic load_pair(input int x, input int w);
      bus.load_valid = 1'b1;
      bus.load_x     = DW'(x);
      bus.load_w     = DW'(w);
      step;
      bus.load_valid = 1'b0;
   endtask

   task automatic load_set(input int xs[N], input int ws[N]);
      for (int i = 0; i < N; i++) load_pair(xs[i], ws[i]);
   endtask

   task automatic push_exp(input logic [AW-1:0] r, input logic o);
      exp_q.push_back({o, r});
      last_res = r;
      last_ov  = o;
   endtask

   task automatic start_and_wait(input int x0, input int w0);
      int cycles;
      bit dropped;
      bus.start = 1'b1;
      step;
      bus.start = 1'b0;
      check("start_busy", bus.busy, 1);
      check("start_mac_x", bus.mac_x, x0);
      check("start_mac_w", bus.mac_w, w0);
      check("start_mac_prev", bus.mac_prev, 0);
      cycles  = 0;
      dropped = 0;
      while (bus.result_valid !== 1'b1 && cycles < 64) begin
         if (bus.busy !== 1'b1) dropped = 1;
         step;
         cycles++;
      end
      check("latency", cycles, N * (LAT + 1));
      check("busy_held", dropped, 0);
      check("done_busy", bus.busy, 0);
      check("done_ready", bus.load_ready, 1);
      n_runs++;
   endtask

   task automatic do_run(input int xs[N], input int ws[N]);
      logic [AW:0] e;
      load_set(xs, ws);
      e = ref_dot(xs, ws);
      push_exp(e[AW-1:0], e[AW]);
      start_and_wait(xs[0], ws[0]);
   endtask

   task automatic check_reset_state(input string pfx);
      check({pfx, "_busy"}, bus.busy, 0);
      check({pfx, "_load_ready"}, bus.load_ready, 1);
      check({pfx, "_mac_x"}, bus.mac_x, 0);
      check({pfx, "_mac_w"}, bus.mac_w, 0);
      check({pfx, "_mac_prev"}, bus.mac_prev, 0);
      check({pfx, "_result"}, bus.result, 0);
      check({pfx, "_result_valid"}, bus.result_valid, 0);
      check({pfx, "_overflow"}, bus.overflow, 0);
   endtask

   task automatic idle_no_pulse(input string tag, input int n);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         if (bus.result_valid === 1'b1) seen++;
         step;
      end
      check(tag, seen, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int xs[N];
      int ws[N];

      rst_n = 1'b0;
      bus.clear = 1'b0;
      bus.load_valid = 1'b0;
      bus.load_x = '0;
      bus.load_w = '0;
      bus.start = 1'b0;
      step;
      step;
      rst_n = 1'b1;
      check_reset_state("rst");

      // Directed dot product: 5+12+21+32 = 70.
      xs = '{1, 2, 3, 4};
      ws = '{5, 6, 7, 8};
      load_set(xs, ws);
      push_exp(8'd70, 1'b0);
      start_and_wait(1, 5);

      // All 15s: 900 mod 256 = 132, wraps.
      xs = '{15, 15, 15, 15};
      ws = '{15, 15, 15, 15};
      load_set(xs, ws);
      push_exp(8'd132, 1'b1);
      start_and_wait(15, 15);
      step;
      step;
      step;
      check("ov_hold", bus.overflow, 1);
      check("result_hold", bus.result, 132);

      // Start with only 3 pairs loaded is ignored.
      load_pair(2, 3);
      load_pair(3, 3);
      load_pair(4, 3);
      bus.start = 1'b1;
      step;
      bus.start = 1'b0;
      check("short_start_busy", bus.busy, 0);
      check("short_start_ready", bus.load_ready, 1);
      check("short_start_ov", bus.overflow, 1);
      load_pair(5, 3);
      check("full_ready", bus.load_ready, 0);
      push_exp(8'd42, 1'b0);
      start_and_wait(2, 3);

      // Single-term result after a wrapping run.
      xs = '{1, 0, 0, 0};
      ws = '{1, 0, 0, 0};
      load_set(xs, ws);
      push_exp(8'd1, 1'b0);
      start_and_wait(1, 1);

      // Fifth pair while full is dropped.
      for (int i = 0; i < N; i++) begin
         xs[i] = $urandom_range(0, 15);
         ws[i] = $urandom_range(0, 15);
      end
      load_set(xs, ws);
      check("fifth_ready", bus.load_ready, 0);
      bus.load_valid = 1'b1;
      bus.load_x = 4'hf;
      bus.load_w = 4'hf;
      step;
      step;
      bus.load_valid = 1'b0;
      mon_e = ref_dot(xs, ws);
      push_exp(mon_e[AW-1:0], mon_e[AW]);
      start_and_wait(xs[0], ws[0]);

      // Load and start in the result_valid cycle: load taken, start ignored.
      bus.load_valid = 1'b1;
      bus.load_x = 4'd7;
      bus.load_w = 4'd9;
      bus.start = 1'b1;
      step;
      bus.load_valid = 1'b0;
      bus.start = 1'b0;
      check("rv_start_busy", bus.busy, 0);
      check("rv_load_ready", bus.load_ready, 1);
      load_pair(1, 1);
      load_pair(1, 2);
      load_pair(1, 3);
      push_exp(8'd69, 1'b0);
      start_and_wait(7, 9);

      // Clear seven cycles into a run.
      for (int i = 0; i < N; i++) begin
         xs[i] = $urandom_range(0, 15);
         ws[i] = $urandom_range(0, 15);
      end
      load_set(xs, ws);
      bus.start = 1'b1;
      step;
      bus.start = 1'b0;
      for (int i = 0; i < 6; i++) step;
      bus.clear = 1'b1;
      step;
      bus.clear = 1'b0;
      check("clr_busy", bus.busy, 0);
      check("clr_ready", bus.load_ready, 1);
      check("clr_result", bus.result, last_res);
      check("clr_overflow", bus.overflow, last_ov);
      bus.start = 1'b1;
      step;
      bus.start = 1'b0;
      check("clr_count_zero", bus.busy, 0);
      idle_no_pulse("clr_no_pulse", 20);

      // Reset for one cycle mid-run.
      for (int i = 0; i < N; i++) begin
         xs[i] = $urandom_range(8, 15);
         ws[i] = $urandom_range(8, 15);
      end
      load_set(xs, ws);
      bus.start = 1'b1;
      step;
      bus.start = 1'b0;
      for (int i = 0; i < 5; i++) step;
      rst_n = 1'b0;
      step;
      rst_n = 1'b1;
      check_reset_state("mrst");
      idle_no_pulse("mrst_no_pulse", 20);

      // Random runs.
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < N; i++) begin
            xs[i] = $urandom_range(0, 15);
            ws[i] = $urandom_range(0, 15);
         end
         do_run(xs, ws);
         for (int k = 0; k < int'($urandom_range(0, 3)); k++) step;
      end

      step;
      step;
      check("pulse_count", n_pulses, n_runs);
      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
